spu32_wb8_arbiter: RTL and testbench
====================================

# spu32_wb8_arbiter

Two-master arbiter for the SPU32 8-bit pipelined Wishbone bus. It sits between the CPU bus port (master 0) and a second master, such as a DMA or video fetcher (master 1), and the shared slave fabric. It grants the bus per cycle-frame (held while the granted master's CYC stays high) with round-robin or fixed priority. A watchdog completes hung transfers with a synthetic ACK so the CPU bus unit cannot lock up.

## Interface
Parameters:
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = master 0 always wins
- TIMEOUT, 255, cycles without ACK_I before a synthetic ACK is issued; 0 disables the watchdog; legal range 0..65535

Ports:
- CLK_I  input  1  bus clock, all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- Mn_CYC_I, Mn_STB_I, Mn_WE_I  input  1 each  master n (n=0,1) cycle/strobe/write
- Mn_ADR_I  input  32  master n address
- Mn_DAT_I  input  8  master n write data
- Mn_DAT_O  output  8  read data to master n
- Mn_ACK_O  output  1  acknowledge to master n
- Mn_STALL_O  output  1  stall to master n
- CYC_O, STB_O, WE_O  output  1 each  to slave
- ADR_O  output  32  to slave
- DAT_O  output  8  to slave
- DAT_I  input  8  read data from slave
- ACK_I, STALL_I  input  1 each  from slave
- GNT_O  output  2  one-hot current grant; 00 = idle
- TIMEOUT_O  output  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE, GRANT0, GRANT1. Registered `last` holds the last-served master.
- IDLE, requests present:
  - only one master has CYC high: go to that master's GRANT state;
  - both high: with ROUND_ROBIN=1, grant the master != `last`; with ROUND_ROBIN=0, grant M0.
- GRANTn: when Mn_CYC_I=0, release. In that same cycle, apply the IDLE arbitration to go straight to the other GRANT state, or to IDLE. Set `last` <= n.
- Slave outputs follow the granted master combinationally. In IDLE, all slave outputs are 0.
- Granted master:
  - ACK_O = ACK_I | wd_fire;
  - STALL_O = STALL_I;
  - DAT_O = wd_fire ? 8'hFF : DAT_I.
- Non-granted master: ACK_O=0, STALL_O=1, DAT_O=DAT_I.
- Each master issues at most one outstanding strobe. The arbiter does not count outstanding transfers.
- Watchdog (16-bit counter):
  - clears on ACK_I, on any state change, and in IDLE;
  - otherwise increments each cycle while the granted CYC is high;
  - fires when count == TIMEOUT-1 and ACK_I=0. Firing gives wd_fire=1 for one cycle, TIMEOUT_O=1, and clears the counter.

## Timing
- Arbitration latency: from IDLE, a CYC rising in cycle t is granted at edge t+1. Its STB reaches the slave in cycle t+1 and is stalled in cycle t.
- Back-to-back handover costs 0 idle cycles. The release cycle has CYC_O=0 because the released master drives CYC low.
- ACK_I arriving in the same cycle the granted CYC drops is still routed to that master.
- ACK_I and watchdog expiry in the same cycle: ACK_I wins, no TIMEOUT_O, counter clears.
- Reset, including mid-transfer: state IDLE, `last`=M1 (so M0 wins the first contention), counter 0.
- Output values during and after reset: GNT_O=00, TIMEOUT_O=0, slave CYC/STB/WE/ADR/DAT all 0, both Mn_ACK_O=0, Mn_STALL_O=1.

## Structure
- A shared package holds the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2), master index constants and the synthetic read value 8'hFF.
- One sub-module, spu32_wb8_watchdog: holds the counter, takes enable/clear inputs and the TIMEOUT parameter, and outputs fire.
- The grant FSM and mux stay in the top module.

## Test plan
- M0 only, read at 0x100 with ACK_I after 2 cycles and DAT_I=8'h5A -> GNT_O=01 at t+1, M0_DAT_O=5A with M0_ACK_O, M1_STALL_O=1 throughout.
- M0 and M1 raise CYC in the same cycle after reset, ROUND_ROBIN=1 -> M0 granted first. M0 drops CYC -> M1 granted at the next edge with no IDLE cycle. Repeat with both requesting -> M1 is not served twice in a row.
- ROUND_ROBIN=0 with both masters requesting continuously, M0 cycling CYC -> M1 is never granted while M0 requests at each release.
- TIMEOUT=4, M1 strobe with no ACK_I -> after 4 cycles, M1_ACK_O=1, M1_DAT_O=FF and TIMEOUT_O=1 for one cycle. With ACK_I in the expiry cycle -> no TIMEOUT_O.
- reset asserted while in GRANT1 with STB_O high -> next cycle GRANT is idle, all slave outputs 0; the next contention goes to M0.

Source files
------------

// File: rtl/spu32_wb8_arbiter_pkg.sv
// Shared definitions for the SPU32 8-bit Wishbone two-master arbiter.
// Holds the grant state encoding, master indices and the arbitration rule.
package spu32_wb8_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  localparam logic       MASTER0      = 1'b0;
  localparam logic       MASTER1      = 1'b1;
  localparam logic [7:0] WD_READ_DATA = 8'hFF;
  localparam int         WD_WIDTH     = 16;

  // Pick the next owner from the two CYC requests; round-robin favours the
  // master that was not served last, fixed priority always favours M0.
  function automatic state_t arbitrate(input logic cyc0, input logic cyc1,
                                       input logic last, input logic round_robin);
    state_t res;
    res = ST_IDLE;
    if (cyc0 && cyc1) begin
      res = (round_robin && last == MASTER0) ? ST_GRANT1 : ST_GRANT0;
    end else if (cyc0) begin
      res = ST_GRANT0;
    end else if (cyc1) begin
      res = ST_GRANT1;
    end
    return res;
  endfunction

endpackage

// File: rtl/spu32_wb8_watchdog.sv
// Bus watchdog: counts granted cycles without ACK and fires once when the
// programmed limit is reached. TIMEOUT=0 disables firing.
module spu32_wb8_watchdog
  import spu32_wb8_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic ack_i,
  output logic fire_o
);

  localparam logic [WD_WIDTH-1:0] LIMIT = WD_WIDTH'(TIMEOUT - 1);

  logic [WD_WIDTH-1:0] count_q, count_d;

  assign fire_o = (TIMEOUT != 0) && en_i && !ack_i && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clr_i || fire_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spu32_wb8_arbiter.sv
// Two-master arbiter for the SPU32 8-bit pipelined Wishbone bus. Grants per
// cycle-frame, routes the slave port to the owner and guards against hung slaves.
module spu32_wb8_arbiter
  import spu32_wb8_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK_I,
  input  logic        reset,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [7:0]  M0_DAT_I,
  output logic [7:0]  M0_DAT_O,
  output logic        M0_ACK_O,
  output logic        M0_STALL_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [7:0]  M1_DAT_I,
  output logic [7:0]  M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        M1_STALL_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [7:0]  DAT_O,
  input  logic [7:0]  DAT_I,
  input  logic        ACK_I,
  input  logic        STALL_I,
  output logic [1:0]  GNT_O,
  output logic        TIMEOUT_O
);

  state_t state_q, state_d, cur_state;
  logic   last_q, last_d;
  logic   gnt0, gnt1;
  logic   wd_en, wd_clr, wd_fire;

  // Reset is synchronous, but the bus must already look idle while it is held.
  assign cur_state = reset ? ST_IDLE : state_q;
  assign gnt0      = (cur_state == ST_GRANT0);
  assign gnt1      = (cur_state == ST_GRANT1);

  always_ff @(posedge CLK_I) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= MASTER1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // A release re-arbitrates in the same cycle so handover costs no idle cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: state_d = arbitrate(M0_CYC_I, M1_CYC_I, last_q, ROUND_ROBIN);
      ST_GRANT0: begin
        if (!M0_CYC_I) begin
          last_d  = MASTER0;
          state_d = arbitrate(M0_CYC_I, M1_CYC_I, MASTER0, ROUND_ROBIN);
        end
      end
      ST_GRANT1: begin
        if (!M1_CYC_I) begin
          last_d  = MASTER1;
          state_d = arbitrate(M0_CYC_I, M1_CYC_I, MASTER1, ROUND_ROBIN);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wd_en  = (gnt0 && M0_CYC_I) || (gnt1 && M1_CYC_I);
  assign wd_clr = ACK_I || (state_d != state_q) || (state_q == ST_IDLE);

  spu32_wb8_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (CLK_I),
    .reset  (reset),
    .en_i   (wd_en),
    .clr_i  (wd_clr),
    .ack_i  (ACK_I),
    .fire_o (wd_fire)
  );

  assign TIMEOUT_O = wd_fire;

  always_comb begin
    CYC_O      = 1'b0;
    STB_O      = 1'b0;
    WE_O       = 1'b0;
    ADR_O      = '0;
    DAT_O      = '0;
    GNT_O      = 2'b00;
    M0_ACK_O   = 1'b0;
    M0_STALL_O = 1'b1;
    M0_DAT_O   = DAT_I;
    M1_ACK_O   = 1'b0;
    M1_STALL_O = 1'b1;
    M1_DAT_O   = DAT_I;
    if (gnt0) begin
      GNT_O      = 2'b01;
      CYC_O      = M0_CYC_I;
      STB_O      = M0_STB_I;
      WE_O       = M0_WE_I;
      ADR_O      = M0_ADR_I;
      DAT_O      = M0_DAT_I;
      M0_ACK_O   = ACK_I | wd_fire;
      M0_STALL_O = STALL_I;
      M0_DAT_O   = wd_fire ? WD_READ_DATA : DAT_I;
    end else if (gnt1) begin
      GNT_O      = 2'b10;
      CYC_O      = M1_CYC_I;
      STB_O      = M1_STB_I;
      WE_O       = M1_WE_I;
      ADR_O      = M1_ADR_I;
      DAT_O      = M1_DAT_I;
      M1_ACK_O   = ACK_I | wd_fire;
      M1_STALL_O = STALL_I;
      M1_DAT_O   = wd_fire ? WD_READ_DATA : DAT_I;
    end
  end

endmodule

// File: tb/tb_spu32_wb8_arbiter.sv
// Bench for spu32_wb8_arbiter: a round-robin/TIMEOUT=4 instance and a fixed-
// priority/no-watchdog instance share stimulus and are checked against a model.
module tb_spu32_wb8_arbiter;

  localparam int TMO_RR = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m1_adr;
  logic [7:0]  m0_dat, m1_dat, dat_i;
  logic        ack_i, stall_i;

  logic [1:0]  gnt    [2];
  logic        cyc_o  [2];
  logic        stb_o  [2];
  logic        we_o   [2];
  logic [31:0] adr_o  [2];
  logic [7:0]  dat_o  [2];
  logic        ack0   [2];
  logic        stall0 [2];
  logic [7:0]  rd0    [2];
  logic        ack1   [2];
  logic        stall1 [2];
  logic [7:0]  rd1    [2];
  logic        tmo_o  [2];

  int checks = 0;
  int failures = 0;

  // Reference model: owner (-1 = nobody), last served master, cycles waited.
  int own [2] = '{-1, -1};
  int lst [2] = '{1, 1};
  int wt  [2] = '{0, 0};

  always #5 clk = ~clk;

  spu32_wb8_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TMO_RR)) dut_rr (
    .CLK_I(clk), .reset(reset),
    .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat),
    .M0_DAT_O(rd0[0]), .M0_ACK_O(ack0[0]), .M0_STALL_O(stall0[0]),
    .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat),
    .M1_DAT_O(rd1[0]), .M1_ACK_O(ack1[0]), .M1_STALL_O(stall1[0]),
    .CYC_O(cyc_o[0]), .STB_O(stb_o[0]), .WE_O(we_o[0]), .ADR_O(adr_o[0]), .DAT_O(dat_o[0]),
    .DAT_I(dat_i), .ACK_I(ack_i), .STALL_I(stall_i), .GNT_O(gnt[0]), .TIMEOUT_O(tmo_o[0])
  );

  spu32_wb8_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(0)) dut_fp (
    .CLK_I(clk), .reset(reset),
    .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat),
    .M0_DAT_O(rd0[1]), .M0_ACK_O(ack0[1]), .M0_STALL_O(stall0[1]),
    .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat),
    .M1_DAT_O(rd1[1]), .M1_ACK_O(ack1[1]), .M1_STALL_O(stall1[1]),
    .CYC_O(cyc_o[1]), .STB_O(stb_o[1]), .WE_O(we_o[1]), .ADR_O(adr_o[1]), .DAT_O(dat_o[1]),
    .DAT_I(dat_i), .ACK_I(ack_i), .STALL_I(stall_i), .GNT_O(gnt[1]), .TIMEOUT_O(tmo_o[1])
  );

  function automatic logic mdl_fire(input int d);
    int   limit;
    logic c;
    limit = (d == 0) ? TMO_RR : 0;
    c = (own[d] == 0) ? m0_cyc : m1_cyc;
    return !reset && limit != 0 && own[d] != -1 && c && !ack_i && wt[d] == limit - 1;
  endfunction

  function automatic logic [65:0] mdl_out(input int d);
    int          o;
    logic        f, c, s, w, a0, s0, a1, s1;
    logic [1:0]  g;
    logic [31:0] a;
    logic [7:0]  dd, r0, r1;
    o = reset ? -1 : own[d];
    f = mdl_fire(d);
    g = 2'b00; c = 1'b0; s = 1'b0; w = 1'b0; a = '0; dd = '0;
    a0 = 1'b0; s0 = 1'b1; r0 = dat_i; a1 = 1'b0; s1 = 1'b1; r1 = dat_i;
    if (o == 0) begin
      g = 2'b01; c = m0_cyc; s = m0_stb; w = m0_we; a = m0_adr; dd = m0_dat;
      a0 = ack_i | f; s0 = stall_i; r0 = f ? 8'hFF : dat_i;
    end else if (o == 1) begin
      g = 2'b10; c = m1_cyc; s = m1_stb; w = m1_we; a = m1_adr; dd = m1_dat;
      a1 = ack_i | f; s1 = stall_i; r1 = f ? 8'hFF : dat_i;
    end
    return {g, c, s, w, a, dd, a0, s0, r0, a1, s1, r1, f};
  endfunction

  function automatic logic [65:0] act_vec(input int d);
    return {gnt[d], cyc_o[d], stb_o[d], we_o[d], adr_o[d], dat_o[d],
            ack0[d], stall0[d], rd0[d], ack1[d], stall1[d], rd1[d], tmo_o[d]};
  endfunction

  always @(posedge clk) begin
    int   nxt, l;
    logic f, c;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        own[d] = -1; lst[d] = 1; wt[d] = 0;
      end else begin
        f = mdl_fire(d);
        c = (own[d] == 0) ? m0_cyc : (own[d] == 1) ? m1_cyc : 1'b0;
        nxt = own[d];
        l = lst[d];
        if (!c) begin
          if (own[d] != -1) l = own[d];
          if (m0_cyc && m1_cyc) nxt = (d == 0) ? 1 - l : 0;
          else if (m0_cyc) nxt = 0;
          else if (m1_cyc) nxt = 1;
          else nxt = -1;
        end
        if (own[d] == -1 || nxt != own[d] || ack_i || f) wt[d] = 0;
        else wt[d] = wt[d] + 1;
        own[d] = nxt;
        lst[d] = l;
      end
    end
  end

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
    dat_i = '0; ack_i = 0; stall_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [65:0] exp_v;
    @(negedge clk);
    reset = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m0_adr = 32'hDEAD_0000;
    m1_adr = 32'h0000_BEEF; m0_dat = 8'h11; m1_dat = 8'h22; dat_i = 8'hC3; ack_i = 1;
    repeat (2) @(negedge clk);
    #1;
    exp_v = {2'b00, 3'b000, 32'h0, 8'h0, 1'b0, 1'b1, dat_i, 1'b0, 1'b1, dat_i, 1'b0};
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== exp_v) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got=%h exp=%h", d, act_vec(d), exp_v);
      end
    end
    @(negedge clk);
    reset = 0;
    clear_inputs();
    #1;
    checks++;
    if (gnt[0] !== 2'b00 || cyc_o[0] !== 1'b0 || stall0[0] !== 1'b1 || stall1[0] !== 1'b1) begin
      failures++;
      $display("FAIL after_reset gnt=%b cyc=%b st0=%b st1=%b exp gnt=00 cyc=0 st=1,1",
               gnt[0], cyc_o[0], stall0[0], stall1[0]);
    end
    $display("test_reset done");
  endtask

  task automatic test_m0_read();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h100;
    #1;
    checks++;
    if (gnt[0] !== 2'b00 || stall0[0] !== 1'b1) begin
      failures++;
      $display("FAIL m0_request_cycle gnt=%b stall=%b exp gnt=00 stall=1", gnt[0], stall0[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b01 || stb_o[0] !== 1'b1 || adr_o[0] !== 32'h100 || stall0[0] !== 1'b0 || stall1[0] !== 1'b1) begin
      failures++;
      $display("FAIL m0_grant gnt=%b stb=%b adr=%h st0=%b st1=%b exp 01 1 00000100 0 1",
               gnt[0], stb_o[0], adr_o[0], stall0[0], stall1[0]);
    end
    @(negedge clk);
    m0_stb = 0;
    #1;
    checks++;
    if (ack0[0] !== 1'b0 || stall1[0] !== 1'b1) begin
      failures++;
      $display("FAIL m0_wait ack=%b st1=%b exp ack=0 st1=1", ack0[0], stall1[0]);
    end
    @(negedge clk);
    ack_i = 1; dat_i = 8'h5A;
    #1;
    checks++;
    if (ack0[0] !== 1'b1 || rd0[0] !== 8'h5A || ack1[0] !== 1'b0 || stall1[0] !== 1'b1 || tmo_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL m0_read_data ack=%b dat=%h ack1=%b st1=%b tmo=%b exp 1 5a 0 1 0",
               ack0[0], rd0[0], ack1[0], stall1[0], tmo_o[0]);
    end
    @(negedge clk);
    ack_i = 0; m0_cyc = 0;
    #1;
    checks++;
    if (gnt[0] !== 2'b01 || cyc_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL m0_release_cycle gnt=%b cyc=%b exp gnt=01 cyc=0", gnt[0], cyc_o[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b00) begin
      failures++;
      $display("FAIL m0_idle_after gnt=%b exp=00", gnt[0]);
    end
    $display("test_m0_read done");
  endtask

  task automatic test_contention();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b01 || gnt[1] !== 2'b01) begin
      failures++;
      $display("FAIL first_contention rr=%b fp=%b exp 01 01", gnt[0], gnt[1]);
    end
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    #1;
    checks++;
    if (gnt[0] !== 2'b01 || cyc_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL handover_release gnt=%b cyc=%b exp 01 0", gnt[0], cyc_o[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b10 || gnt[1] !== 2'b10 || cyc_o[0] !== 1'b1 || adr_o[0] !== 32'h200) begin
      failures++;
      $display("FAIL handover_no_idle rr=%b fp=%b cyc=%b adr=%h exp 10 10 1 00000200",
               gnt[0], gnt[1], cyc_o[0], adr_o[0]);
    end
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0;
    #1;
    checks++;
    if (gnt[0] !== 2'b10) begin
      failures++;
      $display("FAIL m1_release gnt=%b exp=10", gnt[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b01 || gnt[1] !== 2'b01) begin
      failures++;
      $display("FAIL back_to_m0 rr=%b fp=%b exp 01 01", gnt[0], gnt[1]);
    end
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b10 || gnt[1] !== 2'b01) begin
      failures++;
      $display("FAIL policy_after_m0 rr=%b fp=%b exp 10 01", gnt[0], gnt[1]);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    $display("test_contention done");
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_rr;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      exp_rr = (r % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk); #1;
      checks++;
      if (gnt[1] !== 2'b01 || gnt[0] !== exp_rr) begin
        failures++;
        $display("FAIL policy_round%0d fp=%b rr=%b exp fp=01 rr=%b", r, gnt[1], gnt[0], exp_rr);
      end
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      repeat (2) @(negedge clk);
    end
    $display("test_fixed_priority done");
  endtask

  task automatic test_timeout();
    logic exp_t, exp_a;
    do_reset();
    m1_cyc = 1; m1_stb = 1; dat_i = 8'h33;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) m1_stb = 0;
      ack_i = (k == 8);
      dat_i = (k == 8) ? 8'h77 : 8'h33;
      exp_t = (k == 4 || k == 12);
      exp_a = exp_t || (k == 8);
      #1;
      checks++;
      if (tmo_o[0] !== exp_t || ack1[0] !== exp_a || gnt[0] !== 2'b10 ||
          rd1[0] !== (exp_t ? 8'hFF : dat_i) || tmo_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL watchdog_cycle%0d tmo=%b ack=%b gnt=%b dat=%h fp_tmo=%b exp tmo=%b ack=%b gnt=10 dat=%h fp_tmo=0",
                 k, tmo_o[0], ack1[0], gnt[0], rd1[0], tmo_o[1], exp_t, exp_a, exp_t ? 8'hFF : dat_i);
      end
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; stall_i = 1; m1_adr = 32'h300;
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b10 || stb_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup gnt=%b stb=%b exp 10 1", gnt[0], stb_o[0]);
    end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (gnt[0] !== 2'b00 || stb_o[0] !== 1'b0 || cyc_o[0] !== 1'b0 || we_o[0] !== 1'b0 ||
        adr_o[0] !== 32'h0 || stall1[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_outputs gnt=%b stb=%b cyc=%b we=%b adr=%h st1=%b exp 00 0 0 0 0 1",
               gnt[0], stb_o[0], cyc_o[0], we_o[0], adr_o[0], stall1[0]);
    end
    @(negedge clk);
    reset = 0; m0_cyc = 1; m0_stb = 1;
    #1;
    checks++;
    if (gnt[0] !== 2'b00 || cyc_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle gnt=%b cyc=%b exp 00 0", gnt[0], cyc_o[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (gnt[0] !== 2'b01 || gnt[1] !== 2'b01) begin
      failures++;
      $display("FAIL midreset_next_contention rr=%b fp=%b exp 01 01", gnt[0], gnt[1]);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 4) == 0) m0_cyc = !m0_cyc;
      if ($urandom_range(0, 4) == 0) m1_cyc = !m1_cyc;
      m0_stb = m0_cyc & 1'($urandom);
      m1_stb = m1_cyc & 1'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat = 8'($urandom); m1_dat = 8'($urandom); dat_i = 8'($urandom);
      ack_i = ($urandom_range(0, 5) == 0);
      stall_i = ($urandom_range(0, 3) == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act_vec(d) !== mdl_out(d)) begin
          failures++;
          bad++;
          $display("FAIL random_cycle%0d dut=%0d got=%h exp=%h", i, d, act_vec(d), mdl_out(d));
        end
      end
    end
    $display("test_random done cycles=400 mismatching=%0d", bad);
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_m0_read();
    test_contention();
    test_fixed_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
